clock_seg_scan: RTL
===================

// Module: clock_seg_scan
// PURPOSE
//  Consumes the packed wall-clock time word {hour,4'h0,minute,4'h0,second} (BCD)
//  and drives the board's 8-digit multiplexed seven-segment display.
//  Time is snapshotted once per scan frame so a display frame never mixes old and new digits.
//  Per-field blinking supports time-set mode; separator digits show '-' or blank.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per digit slot (100 MHz -> 2 kHz digit, 250 Hz frame)
//  BLINK_FRAMES  125    frames per blink half-period (250 Hz frame -> 1 Hz blink)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  time_in     in   32  [31:24] hour BCD, [23:20] sep, [19:12] min BCD, [11:8] sep, [7:0] sec BCD
//  blink_mask  in   3   bit2 hour, bit1 minute, bit0 second: field blinks when set
//  dash_en     in   1   1: separator digits show '-'; 0: separator digits blank
//  an          out  8   digit enables, active low, an[i] = digit i (digit 7 leftmost)
//  seg         out  8   {dp,g,f,e,d,c,b,a}, active low; dp always 1
//  frame_tick  out  1   1-cycle pulse, high in the cycle after each snapshot
// BEHAVIOUR
//  - Reset (async, immediate): presc=0, scan_idx=0, snap=0, frame_cnt=0, blink_phase=0,
//    an=8'hFF, seg=8'hFF, frame_tick=0.
//  - presc counts 0..SCAN_DIV-1 and wraps. On the edge where presc==SCAN_DIV-1 (tick),
//    scan_idx <= scan_idx+1 mod 8.
//  - Snapshot: on a tick with scan_idx==7 (wrap 7->0), snap <= time_in. frame_tick is
//    registered high for exactly that following cycle. time_in changes at any other time
//    do not affect the display until the next wrap.
//  - Blink: on each wrap, frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and
//    blink_phase toggles.
//  - Outputs are registered from current scan_idx/snap (1-cycle latency):
//    an <= ~(8'b1 << scan_idx). Exactly one bit is low at all times out of reset.
//  - Digit map: 7:snap[31:28] 6:[27:24] 5:separator 4:[19:16] 3:[15:12] 2:separator
//    1:[7:4] 0:[3:0]. Separator nibbles [23:20], [11:8] are ignored.
//  - Glyphs: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90,
//    A 88, b 83, C C6, d A1, E 86, F 8E. Non-BCD nibbles show the hex glyph.
//    The dash glyph is BF. Blank is FF.
//  - Blanking: a digit in field f shows FF when blink_phase==1 and blink_mask[f]==1.
//    A separator digit shows BF when dash_en==1, otherwise FF.
//    an is still driven for blanked digits.
//  - blink_mask and dash_en are sampled live, not snapshotted.
//  - A tick coinciding with a wrap performs snapshot, frame_cnt update and scan_idx wrap
//    in the same edge. Outputs for digit 0 of the new frame use the new snap.
//  - Reset asserted mid-frame aborts the frame. After release, scanning restarts at
//    digit 0 with snap=0, so the display shows 00-00-00 until the first wrap.
// TESTING (bench uses SCAN_DIV=4, BLINK_FRAMES=2)
//  1. Assert rst -> an=FF, seg=FF, frame_tick=0.
//     First edge after release -> an=FE, seg=C0.
//     Digit 2 slot (dash_en=1) -> an=FB, seg=BF.
//  2. time_in=32'h12034056, mask=0, dash_en=1. After the first frame_tick, the next frame
//     shows digits 0..7 = 82, 92, BF, 99, B0, BF, A4, F9.
//     frame_tick pulses every 32 cycles.
//  3. Change time_in to 32'h23059059 during digit 3 of a frame -> that frame keeps 12-34-56.
//     The frame after the next frame_tick shows 23-59-59.
//  4. blink_mask=3'b010 -> digits 3,4 show FF for 2 frames, then 99/B0 for 2 frames, repeating.
//     Other digits are unaffected.
//  5. dash_en=0 -> digits 2,5 show FF while an still strobes FB/DF.
//     time_in=32'h0A0B0C0D -> digit 6 shows 88, digit 4 shows 83.
//  6. Pulse rst during digit 5 -> outputs FF immediately.
//     After release, scan restarts at an=FE showing 00-00-00 until the first frame_tick.

Source files
------------

// File: rtl/clock_seg_scan.sv
// Eight-digit multiplexed seven-segment driver for a packed BCD wall-clock word.
// The time is latched once per scan frame, and each field can blink independently.
module clock_seg_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_in,
  input  logic [2:0]  blink_mask,
  input  logic        dash_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  // Hex glyph lookup, active low {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 8'hC0;
      4'h1: hex_glyph = 8'hF9;
      4'h2: hex_glyph = 8'hA4;
      4'h3: hex_glyph = 8'hB0;
      4'h4: hex_glyph = 8'h99;
      4'h5: hex_glyph = 8'h92;
      4'h6: hex_glyph = 8'h82;
      4'h7: hex_glyph = 8'hF8;
      4'h8: hex_glyph = 8'h80;
      4'h9: hex_glyph = 8'h90;
      4'hA: hex_glyph = 8'h88;
      4'hB: hex_glyph = 8'h83;
      4'hC: hex_glyph = 8'hC6;
      4'hD: hex_glyph = 8'hA1;
      4'hE: hex_glyph = 8'h86;
      4'hF: hex_glyph = 8'h8E;
      default: hex_glyph = 8'hFF;
    endcase
  endfunction

  logic [PW-1:0] presc_r;
  logic [2:0]    scan_idx_r;
  logic [23:0]   snap_r;        // {hour, minute, second}; separator nibbles are never shown
  logic [FW-1:0] frame_cnt_r;
  logic          blink_phase_r;
  logic [7:0]    an_r;
  logic [7:0]    seg_r;
  logic          frame_tick_r;

  logic          tick_s;
  logic          wrap_s;
  logic [3:0]    nib_s;
  logic [1:0]    field_s;
  logic          is_sep_s;
  logic [7:0]    seg_next_s;
  logic          unused_sep_s;

  assign tick_s       = (presc_r == PRESC_MAX);
  assign wrap_s       = tick_s && (scan_idx_r == 3'd7);
  assign unused_sep_s = ^{time_in[23:20], time_in[11:8]};

  // Prescaler, digit index, frame snapshot and blink timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r       <= '0;
      scan_idx_r    <= 3'd0;
      snap_r        <= 24'h000000;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      frame_tick_r  <= 1'b0;
    end else begin
      presc_r      <= tick_s ? '0 : presc_r + 1'b1;
      frame_tick_r <= wrap_s;
      if (tick_s) begin
        scan_idx_r <= scan_idx_r + 3'd1;
      end
      if (wrap_s) begin
        snap_r <= {time_in[31:24], time_in[19:12], time_in[7:0]};
        if (frame_cnt_r == FRAME_MAX) begin
          frame_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + 1'b1;
        end
      end
    end
  end

  // Digit selection and glyph/blanking for the current slot
  always_comb begin
    nib_s    = 4'h0;
    field_s  = 2'd0;
    is_sep_s = 1'b0;
    case (scan_idx_r)
      3'd7: begin nib_s = snap_r[23:20]; field_s = 2'd2; end
      3'd6: begin nib_s = snap_r[19:16]; field_s = 2'd2; end
      3'd5: is_sep_s = 1'b1;
      3'd4: begin nib_s = snap_r[15:12]; field_s = 2'd1; end
      3'd3: begin nib_s = snap_r[11:8];  field_s = 2'd1; end
      3'd2: is_sep_s = 1'b1;
      3'd1: begin nib_s = snap_r[7:4];   field_s = 2'd0; end
      3'd0: begin nib_s = snap_r[3:0];   field_s = 2'd0; end
      default: begin nib_s = 4'h0; field_s = 2'd0; end
    endcase
    if (is_sep_s) begin
      seg_next_s = dash_en ? 8'hBF : 8'hFF;
    end else if (blink_phase_r && blink_mask[field_s]) begin
      seg_next_s = 8'hFF;
    end else begin
      seg_next_s = hex_glyph(nib_s);
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= 8'hFF;
      seg_r <= 8'hFF;
    end else begin
      an_r  <= ~(8'h01 << scan_idx_r);
      seg_r <= seg_next_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign frame_tick = frame_tick_r;

endmodule
